// File: rtl/word_packer.sv
// Packs N_WORDS variable-length, MSB-aligned words per beat into a continuous
// MSB-first bit stream and emits it as BLOCK_SIZE-bit blocks.
// Optional packet flush on in_last: define WORD_PACKER_FLUSH_EN.
module word_packer #(
    parameter  int N_WORDS     = 4,
    parameter  int MAX_LENGTH  = 48,
    parameter  int BLOCK_SIZE  = 32,
    localparam int LENGTH_BITS = $clog2(MAX_LENGTH + 1)
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [N_WORDS*MAX_LENGTH-1:0]  in_words,
    input  logic [N_WORDS*LENGTH_BITS-1:0] in_lengths,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    output logic [BLOCK_SIZE-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last
);

    localparam int TOT    = N_WORDS * MAX_LENGTH;
    localparam int CAP    = TOT + BLOCK_SIZE;
    localparam int FILL_W = $clog2(CAP + 1);

    localparam logic [LENGTH_BITS-1:0] MAX_L = LENGTH_BITS'(MAX_LENGTH);
    localparam logic [FILL_W-1:0]      BS_F  = FILL_W'(BLOCK_SIZE);
    localparam logic [FILL_W:0]        CAP_F = (FILL_W + 1)'(CAP);

    logic [N_WORDS-1:0][MAX_LENGTH-1:0]  lane_word;
    logic [N_WORDS-1:0][LENGTH_BITS-1:0] lane_len;

    // Per-lane clamp and mask: only the top len bits of each slot survive.
    for (genvar g = 0; g < N_WORDS; g++) begin : g_lane
        logic [LENGTH_BITS-1:0] len_raw;
        assign len_raw      = in_lengths[g*LENGTH_BITS +: LENGTH_BITS];
        assign lane_len[g]  = (len_raw > MAX_L) ? MAX_L : len_raw;
        assign lane_word[g] = in_words[g*MAX_LENGTH +: MAX_LENGTH]
                            & ~({MAX_LENGTH{1'b1}} >> lane_len[g]);
    end

    logic [TOT-1:0]    cat_vec;
    logic [FILL_W-1:0] cat_len;

    always_comb begin
        cat_vec = '0;
        cat_len = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            cat_vec = cat_vec | ((TOT'(lane_word[i]) << (TOT - MAX_LENGTH)) >> cat_len);
            cat_len = cat_len + FILL_W'(lane_len[i]);
        end
    end

    logic              rst_done;
    logic              s1_valid;
    logic [TOT-1:0]    s1_vec;
    logic [FILL_W-1:0] s1_len;
    logic [CAP-1:0]    bits_q;
    logic [FILL_W-1:0] fill;
    logic              flush_pend;

    logic              pop, s1_adv, in_fire;
    logic [FILL_W-1:0] pop_amt, fill_after_pop, fill_next;
    logic [CAP-1:0]    bits_shift, bits_app;

    assign out_valid = (fill >= BS_F) || flush_pend;
    assign out_data  = bits_q[CAP-1 -: BLOCK_SIZE];

    // A flush block with fewer than BLOCK_SIZE bits empties the buffer.
    assign pop            = out_valid && out_ready;
    assign pop_amt        = pop ? ((fill >= BS_F) ? BS_F : fill) : '0;
    assign fill_after_pop = fill - pop_amt;

    assign s1_adv   = s1_valid && !flush_pend
                   && (({1'b0, fill_after_pop} + {1'b0, s1_len}) <= CAP_F);
    assign in_ready = rst_done && !flush_pend && (!s1_valid || s1_adv);
    assign in_fire  = in_valid && in_ready;

    assign bits_shift = pop ? (bits_q << BLOCK_SIZE) : bits_q;
    assign bits_app   = s1_adv ? ((CAP'(s1_vec) << BLOCK_SIZE) >> fill_after_pop) : '0;
    assign fill_next  = fill_after_pop + (s1_adv ? s1_len : '0);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done <= 1'b0;
            s1_valid <= 1'b0;
            s1_vec   <= '0;
            s1_len   <= '0;
            bits_q   <= '0;
            fill     <= '0;
        end else begin
            rst_done <= 1'b1;
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_vec   <= cat_vec;
                s1_len   <= cat_len;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            bits_q <= bits_shift | bits_app;
            fill   <= fill_next;
        end
    end

`ifdef WORD_PACKER_FLUSH_EN
    logic s1_last;

    // Flush is armed when the last beat lands in the buffer and clears when the
    // out_last block leaves; stage 1 is frozen meanwhile so packets never mix.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_last    <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if (in_fire)
                s1_last <= in_last;
            if (pop && out_last)
                flush_pend <= 1'b0;
            else if (s1_adv && s1_last)
                flush_pend <= 1'b1;
        end
    end

    assign out_last = flush_pend && (fill <= BS_F);
`else
    logic in_last_unused;

    assign in_last_unused = in_last;
    assign flush_pend     = 1'b0;
    assign out_last       = 1'b0;
`endif

endmodule

// File: tb/tb_word_packer.sv
// Randomized scoreboard bench for word_packer: a bit-queue reference model
// predicts blocks on each accepted beat; a monitor checks every popped block.
module tb_word_packer;

    localparam int NW = 4;
    localparam int ML = 48;
    localparam int BS = 32;
    localparam int LB = 6;
    localparam int WW = NW * ML;
    localparam int LW = NW * LB;

    logic          clk        = 1'b0;
    logic          aresetn    = 1'b1;
    logic [WW-1:0] in_words   = '0;
    logic [LW-1:0] in_lengths = '0;
    logic          in_valid   = 1'b0;
    logic          in_last    = 1'b0;
    logic          out_ready  = 1'b0;
    logic          in_ready;
    logic [BS-1:0] out_data;
    logic          out_valid;
    logic          out_last;

    word_packer #(.N_WORDS(NW), .MAX_LENGTH(ML), .BLOCK_SIZE(BS)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .in_words   (in_words),
        .in_lengths (in_lengths),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    bit            stream_q[$];
    logic [BS:0]   exp_q[$];
    logic [BS-1:0] got_log[$];
    bit            rnd_ready = 1'b0;
    logic          held_v    = 1'b0;
    logic [BS:0]   held      = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [BS-1:0] exp);
        if (idx >= got_log.size()) begin
            tests++;
            fails++;
            $display("FAIL %s: block %0d missing, required %0h", name, idx, exp);
        end else begin
            chk(name, got_log[idx], exp);
        end
    endtask

    // Reference model: the stream is a plain queue of bits; every 32 bits make a block.
    task automatic model_accept(input logic [WW-1:0] w, input logic [LW-1:0] l, input logic last);
        int            len;
        int            produced = 0;
        logic [BS-1:0] blk;
        logic [BS:0]   e;
        for (int i = 0; i < NW; i++) begin
            len = int'(l[i*LB +: LB]);
            if (len > ML) len = ML;
            for (int b = 0; b < len; b++) stream_q.push_back(w[i*ML + ML - 1 - b]);
        end
        while (stream_q.size() >= BS) begin
            for (int b = 0; b < BS; b++) blk[BS-1-b] = stream_q.pop_front();
            exp_q.push_back({1'b0, blk});
            produced++;
        end
`ifdef WORD_PACKER_FLUSH_EN
        if (last) begin
            if (stream_q.size() == 0 && produced > 0) begin
                e = exp_q.pop_back();
                e[BS] = 1'b1;
                exp_q.push_back(e);
            end else begin
                blk = '0;
                for (int b = 0; stream_q.size() > 0; b++) blk[BS-1-b] = stream_q.pop_front();
                exp_q.push_back({1'b1, blk});
            end
        end
`else
        if (last && produced < 0) $display("unreachable");
`endif
    endtask

    always @(negedge clk) begin
        if (aresetn && in_valid && in_ready) model_accept(in_words, in_lengths, in_last);
    end

    always @(negedge clk) begin
        logic [BS:0] e;
        if (!aresetn) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_block", 64'({out_last, out_data}), 64'(held));
            end
            held_v = out_valid && !out_ready;
            held   = {out_last, out_data};
            if (out_valid && out_ready) begin
                got_log.push_back(out_data);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_block: got %0h, required no block", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("block_data", 64'(out_data), 64'(e[BS-1:0]));
                    chk("block_last", 64'(out_last), 64'(e[BS]));
                end
            end
        end
    end

    task automatic send_beat(input logic [WW-1:0] w, input logic [LW-1:0] l, input logic last);
        int t = 0;
        in_words   = w;
        in_lengths = l;
        in_last    = last;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int bound);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        stream_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] rand_words();
        logic [WW-1:0] r;
        for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [WW-1:0] w030;
    logic [LW-1:0] l030;

    initial begin
        w030 = {48'hDDD000000000, 48'hCCCCCC000000, 48'hBBBBBBBBB000, 48'hAAAAAAAAAAAA};
        l030 = {6'd12, 6'd24, 6'd36, 6'd48};

        #1 aresetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'(1));

        // Reference beat, with latency check
        out_ready = 1'b1;
        got_log.delete();
        send_beat(w030, l030, 1'b1);
        @(negedge clk);
        chk("latency_edge_k", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("latency_edge_k1", 64'(out_valid), 64'(1));
        drain(100);
        chk_log("ref_blk0", 0, 32'hAAAAAAAA);
        chk_log("ref_blk1", 1, 32'hAAAABBBB);
        chk_log("ref_blk2", 2, 32'hBBBBBCCC);
`ifdef WORD_PACKER_FLUSH_EN
        chk_log("ref_blk3", 3, 32'hCCCDDD00);
        chk("ref_count", 64'(got_log.size()), 64'(4));
`else
        chk("ref_count", 64'(got_log.size()), 64'(3));
`endif
        repeat (3) @(negedge clk);
        chk("ref_idle_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Second identical beat continues the partial remainder
        got_log.delete();
        send_beat(w030, l030, 1'b0);
        drain(100);
`ifdef WORD_PACKER_FLUSH_EN
        chk_log("second_blk0", 0, 32'hAAAAAAAA);
`else
        chk_log("second_blk0", 0, 32'hCCCDDDAA);
`endif

        // Asynchronous reset while a block is presented
        out_ready = 1'b0;
        send_beat(w030, l030, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 aresetn = 1'b0;
        stream_q.delete();
        exp_q.delete();
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_data", 64'(out_data), 64'(0));
        chk("async_rst_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        #2 aresetn = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got_log.delete();
        send_beat(w030, l030, 1'b0);
        drain(100);
        chk_log("fresh_blk0", 0, 32'hAAAAAAAA);

        // Over-long lengths clamp to 48
        do_reset();
        got_log.delete();
        send_beat(rand_words(), {4{6'd63}}, 1'b0);
        drain(100);
        chk("clamp_count", 64'(got_log.size()), 64'(6));

        // Zero-length beats produce nothing
        for (int i = 0; i < 4; i++) send_beat(rand_words(), '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_len_valid", 64'(out_valid), 64'(0));
            chk("zero_len_ready", 64'(in_ready), 64'(1));
        end
        @(posedge clk);
        #1;

        // Back-pressure: four full beats with out_ready low
        do_reset();
        got_log.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_beat(rand_words(), {4{6'd48}}, 1'b0);
            end
            begin
                bit saw_low = 1'b0;
                repeat (12) begin
                    @(negedge clk);
                    if (!in_ready) saw_low = 1'b1;
                end
                chk("bp_ready_low", 64'(saw_low), 64'(1));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(200);
        chk("bp_count", 64'(got_log.size()), 64'(24));

        // Randomized traffic with random back-pressure
        do_reset();
        rnd_ready = 1'b1;
        fork
            while (rnd_ready) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int n = 0; n < 300; n++) begin
            logic [LW-1:0] l;
            logic          last;
            for (int i = 0; i < NW; i++)
                l[i*LB +: LB] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(49, 63))
                                                             : 6'($urandom_range(0, 48));
`ifdef WORD_PACKER_FLUSH_EN
            last = ($urandom_range(0, 7) == 0);
            if (last && l[LB-1:0] == 0) l[LB-1:0] = 6'd1;
`else
            last = $urandom_range(0, 1);
`endif
            send_beat(rand_words(), l, last);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        drain(2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter N_WORDS, default 4, number of variable-length words per input beat.
REQ-002 SHALL have parameter MAX_LENGTH, default 48, bit width of each input word slot.
REQ-003 SHALL have parameter BLOCK_SIZE, default 32, output block width in bits.
REQ-004 SHALL have derived parameter LENGTH_BITS = $clog2(MAX_LENGTH+1), not overridden.
REQ-005 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-006 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_words  input  N_WORDS*MAX_LENGTH  word i in slice i; word 0 first in stream; valid bits MSB-aligned in slot.
REQ-008 SHALL have port in_lengths  input  N_WORDS*LENGTH_BITS  length of word i in slice i.
REQ-009 SHALL have port in_valid / in_ready  input / output  1 each  input handshake.
REQ-010 SHALL have port in_last  input  1  final beat of packet (flush request).
REQ-011 SHALL have port out_data  output  BLOCK_SIZE  packed block, first stream bit at MSB.
REQ-012 SHALL have port out_valid / out_ready  output / input  1 each  output handshake.
REQ-013 SHALL have port out_last  output  1  marks final block of packet.

Function
REQ-014 Beat accepted at rising edge with in_valid && in_ready; otherwise inputs ignored.
REQ-015 Lengths > MAX_LENGTH clamp to MAX_LENGTH; bits below a word's length SHALL be masked to zero.
REQ-016 Stage 1 (registered): concatenate the N_WORDS words into one contiguous MSB-first vector plus total length (0..N_WORDS*MAX_LENGTH).
REQ-017 Stage 2: bit buffer, capacity C = N_WORDS*MAX_LENGTH + BLOCK_SIZE, fill counter 0..C; stage-1 vector appended directly after the current fill.
REQ-018 Stage 1 advances when fill after this cycle's pop + stage-1 length <= C; in_ready = stage 1 empty or advancing, and no flush pending.
REQ-019 out_valid SHALL be high when fill >= BLOCK_SIZE or a flush block is pending; out_data = top BLOCK_SIZE buffer bits.
REQ-020 Pop at edge with out_valid && out_ready: fill decreases by BLOCK_SIZE (to 0 for a flush block), buffer shifts left.
REQ-021 Append and pop in the same cycle SHALL both take effect; fill_next = fill - popped + appended.
REQ-022 out_data/out_valid/out_last SHALL be held stable while out_valid && !out_ready.
REQ-023 Latency: beat accepted at edge k; first resulting block valid in the cycle after edge k+1.
REQ-024 Zero-total-length beat without in_last SHALL produce no output and no fill change.
REQ-025 Throughput: one beat per cycle while out_ready high and BLOCK_SIZE >= beat length; else limited to one block per cycle.

Reset
REQ-026 aresetn low SHALL asynchronously clear fill, stage 1, flush state; out_valid=0, out_last=0, out_data=0, in_ready=0.
REQ-027 in_ready SHALL go high the first cycle after aresetn deasserts; reset mid-packet discards all buffered bits.

Configuration
REQ-028 Macro WORD_PACKER_FLUSH_EN defined: once an in_last beat is appended, remaining bits emit as full blocks, then a final partial block zero-padded at LSBs with out_last=1; if the remainder is exactly 0 after a nonempty packet, the last full block carries out_last; an empty buffer flushed emits one all-zero block with out_last=1; in_ready low until that block pops.
REQ-029 Macro not defined: in_last ignored, out_last tied 0, partial bits held until completed by later beats.

Verification (N_WORDS=4, MAX_LENGTH=48, BLOCK_SIZE=32)
REQ-030 Words A..A(48b), B..B000(36), CCCCCC000000(24), DDD000000000(12), in_last=1, out_ready=1 -> 0xAAAAAAAA, 0xAAAABBBB, 0xBBBBBCCC, 0xCCCDDD00 (out_last=1 only on last).
REQ-031 Same beat, in_last=0, macro undefined -> three blocks, fill=24; second identical beat -> first block 0xCCCDDDAA.
REQ-032 Four 48-bit beats back-to-back with out_ready=0 -> in_ready falls, no block lost; release -> 24 consecutive blocks in stream order.
REQ-033 Lengths all 63 -> treated as 48; all lengths 0 -> no out_valid, in_ready stays 1.
REQ-034 aresetn pulsed low with fill=24 and out_valid high -> out_valid drops immediately; next beat's first block starts fresh at MSB.
